// File: rtl/link_ctrl_if.sv
// Bundle of user-side, TX-lane and RX-lane signals of the link controller.
// The slave modport is the controller itself; the master modport is whatever
// drives the user beats and the deserialiser side (a testbench or the lanes).
interface link_ctrl_if;
    logic       tx_valid_in;
    logic [7:0] tx_data_in;
    logic       tx_ready;
    logic       tx_drop;
    logic [7:0] ser_data;
    logic       ser_valid;
    logic [7:0] des_data;
    logic       des_active;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       link_up;
    logic [1:0] state;
    logic       timeout;

    modport master (
        output tx_valid_in,
        output tx_data_in,
        output des_data,
        output des_active,
        input  tx_ready,
        input  tx_drop,
        input  ser_data,
        input  ser_valid,
        input  rx_data,
        input  rx_valid,
        input  link_up,
        input  state,
        input  timeout
    );

    modport slave (
        input  tx_valid_in,
        input  tx_data_in,
        input  des_data,
        input  des_active,
        output tx_ready,
        output tx_drop,
        output ser_data,
        output ser_valid,
        output rx_data,
        output rx_valid,
        output link_up,
        output state,
        output timeout
    );
endinterface

// File: rtl/link_ctrl.sv
// Link controller: trains a serial link with COM symbols, carries user bytes
// while ACTIVE, and retrains through RECOVER on lane loss or remote request.
// Optional TRAIN watchdog is compiled in when TRAIN_TIMEOUT_EN is defined;
// without it TRAIN waits forever and the timeout output is tied low.
module link_ctrl #(
    parameter int COM_TX_COUNT   = 4,
    parameter int COM_RX_COUNT   = 4,
    parameter int ERR_LIMIT      = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    link_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RST     = 2'd0,
        ST_TRAIN   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;

    localparam int TXW = $clog2(COM_TX_COUNT + 1);
    localparam int RXW = $clog2(COM_RX_COUNT + 1);
    localparam int EW  = $clog2(ERR_LIMIT + 1);

    localparam logic [TXW-1:0] TX_MAX  = TXW'(COM_TX_COUNT);
    localparam logic [TXW-1:0] TX_LAST = TXW'(COM_TX_COUNT - 1);
    localparam logic [RXW-1:0] RX_MAX  = RXW'(COM_RX_COUNT);
    localparam logic [EW-1:0]  ERR_LAST = EW'(ERR_LIMIT - 1);

    // Every count must allow at least one cycle, otherwise the *_LAST values wrap.
    if (COM_TX_COUNT < 1 || COM_RX_COUNT < 1 || ERR_LIMIT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("link_ctrl: count parameters must be at least 1");
    end

    state_t         state_q,     state_d;
    logic [TXW-1:0] tx_cnt_q,    tx_cnt_d;
    logic [RXW-1:0] rx_cnt_q,    rx_cnt_d;
    logic [EW-1:0]  err_cnt_q,   err_cnt_d;
    logic [7:0]     ser_data_q,  ser_data_d;
    logic           ser_valid_q, ser_valid_d;
    logic [7:0]     rx_data_q,   rx_data_d;
    logic           rx_valid_q,  rx_valid_d;
    logic           tx_drop_q,   tx_drop_d;
    logic           tx_ready;
    logic           accept;

`ifdef TRAIN_TIMEOUT_EN
    localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMW-1:0] TMO_LAST = TMW'(TIMEOUT_CYCLES - 1);

    logic [TMW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic           timeout_q, timeout_d;
`endif

    function automatic logic is_reserved(input logic [7:0] b);
        return (b == COM) || (b == IDL);
    endfunction

    // User side may only hand over beats while the link is up.
    always_comb begin
        tx_ready = (state_q == ST_ACTIVE);
        accept   = tx_ready && bus.tx_valid_in;
    end

    // Next-state, counter and registered-output logic for the link FSM.
    always_comb begin
        state_d     = state_q;
        tx_cnt_d    = tx_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        err_cnt_d   = err_cnt_q;
        ser_data_d  = ser_data_q;
        ser_valid_d = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_drop_d   = 1'b0;
`ifdef TRAIN_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        timeout_d   = 1'b0;
`endif

        case (state_q)
            ST_RST: begin
                ser_data_d = 8'h00;
                tx_cnt_d   = '0;
                rx_cnt_d   = '0;
                err_cnt_d  = '0;
                state_d    = ST_TRAIN;
            end

            ST_TRAIN: begin
                ser_data_d  = COM;
                ser_valid_d = 1'b1;
                if (tx_cnt_q < TX_MAX) begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
                if (bus.des_active && (bus.des_data == COM)) begin
                    if (rx_cnt_q < RX_MAX) begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = '0;
                end
`ifdef TRAIN_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                if ((tx_cnt_q >= TX_MAX) && (rx_cnt_q >= RX_MAX)) begin
                    state_d  = ST_ACTIVE;
                    tx_cnt_d = '0;
                    rx_cnt_d = '0;
`ifdef TRAIN_TIMEOUT_EN
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = ST_RECOVER;
                    timeout_d = 1'b1;
                    tx_cnt_d  = '0;
                    rx_cnt_d  = '0;
                    tmo_cnt_d = '0;
`endif
                end
            end

            ST_ACTIVE: begin
                ser_valid_d = 1'b1;
                if (accept && !is_reserved(bus.tx_data_in)) begin
                    ser_data_d = bus.tx_data_in;
                end else begin
                    ser_data_d = IDL;
                    tx_drop_d  = accept;
                end
                if (bus.des_active) begin
                    err_cnt_d = '0;
                    if (bus.des_data == COM) begin
                        state_d = ST_RECOVER;
                    end else if (bus.des_data != IDL) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = bus.des_data;
                    end
                end else if (err_cnt_q == ERR_LAST) begin
                    err_cnt_d = '0;
                    state_d   = ST_RECOVER;
                end else begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
            end

            ST_RECOVER: begin
                ser_data_d  = COM;
                ser_valid_d = 1'b1;
                if (tx_cnt_q == TX_LAST) begin
                    state_d   = ST_TRAIN;
                    tx_cnt_d  = '0;
                    rx_cnt_d  = '0;
                    err_cnt_d = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RST;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            err_cnt_q   <= '0;
            ser_data_q  <= 8'h00;
            ser_valid_q <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_drop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            err_cnt_q   <= err_cnt_d;
            ser_data_q  <= ser_data_d;
            ser_valid_q <= ser_valid_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_drop_q   <= tx_drop_d;
        end
    end

`ifdef TRAIN_TIMEOUT_EN
    // Watchdog counter and its one-cycle expiry pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.tx_ready  = tx_ready;
    assign bus.tx_drop   = tx_drop_q;
    assign bus.ser_data  = ser_data_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.link_up   = (state_q == ST_ACTIVE);
    assign bus.state     = state_q;

endmodule

// File: tb/tb_link_ctrl.sv
// Scoreboard bench for link_ctrl: directed stimulus pushes the hand-computed
// data beats it expects; monitors pop and compare whenever the DUT shows a
// non-COM TX beat or a valid RX byte.
module tb_link_ctrl;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;

    typedef struct {
        logic [7:0] data;
        logic       drop;
    } ser_exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    ser_exp_t   ser_q[$];
    logic [7:0] rx_q[$];

    link_ctrl_if bus ();

    link_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, first rising edge at 5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the flow ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the end of the run");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, register the expected beats, step past the edge.
    task automatic apply_stimulus(input logic tv, input logic [7:0] td,
                                  input logic da, input logic [7:0] dd,
                                  input logic push_ser, input logic [7:0] exp_ser, input logic exp_drop,
                                  input logic push_rx, input logic [7:0] exp_rx);
        ser_exp_t e;
        bus.tx_valid_in = tv;
        bus.tx_data_in  = td;
        bus.des_active  = da;
        bus.des_data    = dd;
        if (push_ser) begin
            e.data = exp_ser;
            e.drop = exp_drop;
            ser_q.push_back(e);
        end
        if (push_rx) begin
            rx_q.push_back(exp_rx);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_state"},     {6'd0, bus.state}, 8'd0);
        check_output({tag, "_ser_valid"}, {7'd0, bus.ser_valid}, 8'd0);
        check_output({tag, "_ser_data"},  bus.ser_data, 8'h00);
        check_output({tag, "_rx_valid"},  {7'd0, bus.rx_valid}, 8'd0);
        check_output({tag, "_rx_data"},   bus.rx_data, 8'h00);
        check_output({tag, "_tx_drop"},   {7'd0, bus.tx_drop}, 8'd0);
        check_output({tag, "_timeout"},   {7'd0, bus.timeout}, 8'd0);
        check_output({tag, "_link_up"},   {7'd0, bus.link_up}, 8'd0);
        check_output({tag, "_tx_ready"},  {7'd0, bus.tx_ready}, 8'd0);
    endtask

    // From reset release with COM arriving continuously: TRAIN for five cycles, ACTIVE on the sixth.
    task automatic bring_up();
        for (int k = 1; k <= 6; k++) begin
            apply_stimulus(1'b0, 8'h00, 1'b1, COM, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
            check_output($sformatf("bringup_state_%0d", k), {6'd0, bus.state}, (k < 6) ? 8'd1 : 8'd2);
            if (k == 1) begin
                check_output("bringup_first_ser_valid", {7'd0, bus.ser_valid}, 8'd0);
            end
            if (k == 2) begin
                check_output("bringup_train_ser_valid", {7'd0, bus.ser_valid}, 8'd1);
                check_output("bringup_train_ser_data", bus.ser_data, COM);
            end
        end
        check_output("bringup_link_up", {7'd0, bus.link_up}, 8'd1);
        check_output("bringup_tx_ready", {7'd0, bus.tx_ready}, 8'd1);
    endtask

    // TX monitor: every non-COM beat on the lane must match the head of the queue.
    always @(negedge clk) begin
        ser_exp_t e;
        if (bus.ser_valid === 1'b1 && bus.ser_data !== COM) begin
            checks++;
            if (ser_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL ser_unexpected actual=%h drop=%b expected=none", bus.ser_data, bus.tx_drop);
            end else begin
                e = ser_q.pop_front();
                if (bus.ser_data !== e.data || bus.tx_drop !== e.drop) begin
                    failures++;
                    $display("[TB] FAIL ser_beat actual=%h drop=%b expected=%h drop=%b",
                             bus.ser_data, bus.tx_drop, e.data, e.drop);
                end
            end
        end else if (bus.tx_drop !== 1'b0) begin
            checks++;
            failures++;
            $display("[TB] FAIL stray_tx_drop actual=%b expected=0", bus.tx_drop);
        end
    end

    // RX monitor: every valid received byte must match the head of the queue.
    always @(negedge clk) begin
        logic [7:0] exp_rx;
        if (bus.rx_valid === 1'b1) begin
            checks++;
            if (rx_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL rx_unexpected actual=%h expected=none", bus.rx_data);
            end else begin
                exp_rx = rx_q.pop_front();
                if (bus.rx_data !== exp_rx) begin
                    failures++;
                    $display("[TB] FAIL rx_byte actual=%h expected=%h", bus.rx_data, exp_rx);
                end
            end
        end
    end

    // Directed test sequence.
    initial begin
        int  n;
        logic seen_timeout;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.tx_valid_in = 1'b0;
        bus.tx_data_in  = 8'h00;
        bus.des_active  = 1'b0;
        bus.des_data    = 8'h00;

        $display("[TB] reset and bring-up");
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check_reset_values("por");
        reset = 1'b0;
        bring_up();

        $display("[TB] transmit path");
        apply_stimulus(1'b1, 8'h11, 1'b1, IDL, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b1, 8'h22, 1'b1, IDL, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 8'h00, 1'b1, IDL, 1'b1, IDL,   1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b1, COM,   1'b1, IDL, 1'b1, IDL,   1'b1, 1'b0, 8'h00);
        apply_stimulus(1'b1, IDL,   1'b1, IDL, 1'b1, IDL,   1'b1, 1'b0, 8'h00);
        apply_stimulus(1'b0, 8'h00, 1'b1, IDL, 1'b1, IDL,   1'b0, 1'b0, 8'h00);

        $display("[TB] receive path");
        apply_stimulus(1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, IDL, 1'b0, 1'b1, 8'h5A);
        apply_stimulus(1'b0, 8'h00, 1'b1, IDL,   1'b1, IDL, 1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, IDL, 1'b0, 1'b1, 8'hA5);
        check_output("active_after_rx", {6'd0, bus.state}, 8'd2);

        $display("[TB] lane loss handling");
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, IDL, 1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, IDL, 1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 8'h00, 1'b1, IDL,   1'b1, IDL, 1'b0, 1'b0, 8'h00);
        check_output("two_losses_stay_active", {6'd0, bus.state}, 8'd2);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, IDL, 1'b0, 1'b0, 8'h00);
        end
        check_output("three_losses_recover", {6'd0, bus.state}, 8'd3);
        check_output("recover_link_up", {7'd0, bus.link_up}, 8'd0);
        check_output("recover_tx_ready", {7'd0, bus.tx_ready}, 8'd0);
        for (int r = 1; r <= 4; r++) begin
            apply_stimulus(1'b1, 8'h33, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
            check_output($sformatf("recover_com_%0d", r), bus.ser_data, COM);
            check_output($sformatf("recover_state_%0d", r), {6'd0, bus.state}, (r < 4) ? 8'd3 : 8'd1);
        end

        $display("[TB] training with a broken COM run");
        for (int t = 1; t <= 8; t++) begin
            apply_stimulus(1'b0, 8'h00, 1'b1, (t == 4) ? 8'h55 : COM, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
            check_output($sformatf("train_hold_%0d", t), {6'd0, bus.state}, 8'd1);
        end
        apply_stimulus(1'b0, 8'h00, 1'b1, IDL, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check_output("train_to_active", {6'd0, bus.state}, 8'd2);
        apply_stimulus(1'b1, 8'hC3, 1'b1, 8'h3C, 1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C);

        $display("[TB] reset in the middle of ACTIVE");
        reset = 1'b1;
        apply_stimulus(1'b1, 8'h44, 1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check_reset_values("mid_reset");
        apply_stimulus(1'b1, 8'h44, 1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check_reset_values("mid_reset_hold");
        reset = 1'b0;
        bring_up();

        $display("[TB] remote retrain");
        apply_stimulus(1'b0, 8'h00, 1'b1, IDL, 1'b1, IDL, 1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b1, 8'h99, 1'b1, COM, 1'b1, 8'h99, 1'b0, 1'b0, 8'h00);
        check_output("remote_com_recover", {6'd0, bus.state}, 8'd3);
        check_output("remote_com_rx_valid", {7'd0, bus.rx_valid}, 8'd0);
        for (int r = 1; r <= 4; r++) begin
            apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
            check_output($sformatf("retrain_state_%0d", r), {6'd0, bus.state}, (r < 4) ? 8'd3 : 8'd1);
        end

`ifdef TRAIN_TIMEOUT_EN
        $display("[TB] training watchdog");
        n = 0;
        seen_timeout = 1'b0;
        while (!seen_timeout && n < 200) begin
            apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
            n++;
            seen_timeout = (bus.timeout === 1'b1);
        end
        check_output("timeout_cycles", 8'(n), 8'd64);
        check_output("timeout_to_recover", {6'd0, bus.state}, 8'd3);
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check_output("timeout_single_pulse", {7'd0, bus.timeout}, 8'd0);
`else
        $display("[TB] training without watchdog");
        seen_timeout = 1'b0;
        for (n = 0; n < 80; n++) begin
            apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
            if (bus.timeout !== 1'b0) begin
                seen_timeout = 1'b1;
            end
        end
        check_output("no_timeout_seen", {7'd0, seen_timeout}, 8'd0);
        check_output("train_waits", {6'd0, bus.state}, 8'd1);
`endif

        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check_output("ser_queue_drained", 8'(ser_q.size()), 8'd0);
        check_output("rx_queue_drained", 8'(rx_q.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
